// File: rtl/frame_deserializer_if.sv
// -----------------------------------------------------------------------------
// frame_deserializer_if
// Purpose : groups the serial-side strobe/data and the parallel-side
//           valid/ready handshake of the frame deserializer into one bundle.
// Signals : SAMPLE_ENABLE        bit strobe from the oversampler
//           DEBOUNCED_DATA       synchronised, debounced serial line
//           DATA_READY           consumer accepts the presented word
//           PARALLEL_DATA_OUTPUT received word, LSB received first
//           DATA_VALID           word presented and not yet accepted
//           PARITY_ERROR         parity flag for the presented word
//           FRAME_ERROR          one-cycle pulse, frame dropped (stop/timeout)
//           OVERRUN              one-cycle pulse, good frame dropped (full)
// Modports: master drives the strobe/data/ready side, slave is the deserializer.
// -----------------------------------------------------------------------------
interface frame_deserializer_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  SAMPLE_ENABLE;
   logic                  DEBOUNCED_DATA;
   logic                  DATA_READY;
   logic [DATA_WIDTH-1:0] PARALLEL_DATA_OUTPUT;
   logic                  DATA_VALID;
   logic                  PARITY_ERROR;
   logic                  FRAME_ERROR;
   logic                  OVERRUN;

   modport master (
      output SAMPLE_ENABLE, DEBOUNCED_DATA, DATA_READY,
      input  PARALLEL_DATA_OUTPUT, DATA_VALID, PARITY_ERROR, FRAME_ERROR, OVERRUN
   );

   modport slave (
      input  SAMPLE_ENABLE, DEBOUNCED_DATA, DATA_READY,
      output PARALLEL_DATA_OUTPUT, DATA_VALID, PARITY_ERROR, FRAME_ERROR, OVERRUN
   );
endinterface

// File: rtl/frame_deserializer.sv
// -----------------------------------------------------------------------------
// frame_deserializer
// Purpose : receives frames of start(0), DATA_WIDTH data bits LSB first, one
//           parity bit and one stop(1) bit, sampled on SAMPLE_ENABLE strobes,
//           and presents each completed word on a valid/ready output register.
// Ports   : CONTROL_CLOCK  sole clock, rising edge
//           RESET_N        asynchronous active-low reset
//           bus            frame_deserializer_if.slave (see interface header)
// Config  : define FRAME_TIMEOUT_EN to abandon a partial frame after
//           TIMEOUT_CYCLES clocks without a SAMPLE_ENABLE strobe; without it a
//           partial frame waits indefinitely and no timeout counter exists.
// -----------------------------------------------------------------------------
module frame_deserializer #(
   parameter int DATA_WIDTH     = 8,
   parameter int PARITY_ODD     = 1,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic                 CONTROL_CLOCK,
   input logic                 RESET_N,
   frame_deserializer_if.slave bus
);

   localparam int             CW       = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_WIDTH - 1);
   localparam logic           PAR_ODD  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

   // Reject illegal configurations at elaboration time
   if ((DATA_WIDTH < 5) || (DATA_WIDTH > 16) || (TIMEOUT_CYCLES < 2)) begin : g_param_check
      $error("frame_deserializer: illegal parameter value");
   end

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   state_t                state_q,  state_d;
   logic [CW-1:0]         cnt_q,    cnt_d;
   logic [DATA_WIDTH-1:0] shift_q,  shift_d;
   logic                  fperr_q,  fperr_d;   // parity error of frame in flight
   logic [DATA_WIDTH-1:0] data_q,   data_d;
   logic                  valid_q,  valid_d;
   logic                  perr_q,   perr_d;
   logic                  ferr_q,   ferr_d;
   logic                  ovr_q,    ovr_d;
   logic                  complete_s;

`ifdef FRAME_TIMEOUT_EN
   localparam int         TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]         tmo_q,    tmo_d;
`endif

   // Even-count XOR of data plus parity bit, compared against the selected sense
   function automatic logic parity_err(input logic [DATA_WIDTH-1:0] d, input logic p);
      return (((^d) ^ p) != PAR_ODD) ? 1'b1 : 1'b0;
   endfunction

   // Next-state logic: frame FSM, output register, optional timeout
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      fperr_d    = fperr_q;
      data_d     = data_q;
      valid_d    = valid_q;
      perr_d     = perr_q;
      ferr_d     = 1'b0;
      ovr_d      = 1'b0;
      complete_s = 1'b0;
`ifdef FRAME_TIMEOUT_EN
      tmo_d      = tmo_q;
`endif

      if (bus.SAMPLE_ENABLE) begin
         case (state_q)
            ST_IDLE: begin
               if (!bus.DEBOUNCED_DATA) begin
                  state_d = ST_DATA;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_DATA: begin
               // LSB arrives first, so shift in from the top
               shift_d = {bus.DEBOUNCED_DATA, shift_q[DATA_WIDTH-1:1]};
               if (cnt_q == LAST_BIT) begin
                  state_d = ST_PARITY;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            ST_PARITY: begin
               fperr_d = parity_err(shift_q, bus.DEBOUNCED_DATA);
               state_d = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (bus.DEBOUNCED_DATA) begin
                  complete_s = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end

`ifdef FRAME_TIMEOUT_EN
      // Clocks since last strobe; only meaningful while a frame is open
      if ((state_q == ST_IDLE) || bus.SAMPLE_ENABLE) begin
         tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
         tmo_d   = '0;
         state_d = ST_IDLE;
         ferr_d  = 1'b1;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end
`endif

      // Output register: a completion may reuse the slot freed on this edge
      if (complete_s) begin
         if (!valid_q || bus.DATA_READY) begin
            data_d  = shift_q;
            perr_d  = fperr_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && bus.DATA_READY) begin
         valid_d = 1'b0;
         perr_d  = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State and output registers
   always_ff @(posedge CONTROL_CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         fperr_q <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         fperr_q <= fperr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
`ifdef FRAME_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   assign bus.PARALLEL_DATA_OUTPUT = data_q;
   assign bus.DATA_VALID           = valid_q;
   assign bus.PARITY_ERROR         = perr_q;
   assign bus.FRAME_ERROR          = ferr_q;
   assign bus.OVERRUN              = ovr_q;

endmodule

// File: tb/tb_frame_deserializer.sv
// -----------------------------------------------------------------------------
// tb_frame_deserializer
// Purpose : directed self-checking bench for frame_deserializer (8-bit, odd
//           parity). Expected words are queued when a frame is sent and popped
//           when the deserializer presents its output.
// -----------------------------------------------------------------------------
module tb_frame_deserializer;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   frame_deserializer_if #(.DATA_WIDTH(8)) bus ();

   frame_deserializer #(
      .DATA_WIDTH    (8),
      .PARITY_ODD    (1),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .CONTROL_CLOCK(clk),
      .RESET_N      (rst_n),
      .bus          (bus)
   );

   int         errors = 0;
   int         checks = 0;
   logic [8:0] exp_q[$];   // {parity_error, data}

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bus.SAMPLE_ENABLE  = 1'b1;
      bus.DEBOUNCED_DATA = b;
      tick();
      bus.SAMPLE_ENABLE  = 1'b0;
      bus.DEBOUNCED_DATA = 1'b1;
   endtask

   // Start bit, data LSB first, parity bit; stop bit left to the caller
   task automatic send_head(input logic [7:0] d, input logic p);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(p);
   endtask

   function automatic logic odd_par(input logic [7:0] d);
      return ~(^d);
   endfunction

   task automatic check_delivery(input string tag);
      logic [8:0] e;
      check({tag, "_valid"}, {15'd0, bus.DATA_VALID}, 16'd1);
      check({tag, "_sb_depth"}, 16'(exp_q.size()), 16'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, "_data"}, {8'd0, bus.PARALLEL_DATA_OUTPUT}, {8'd0, e[7:0]});
         check({tag, "_perr"}, {15'd0, bus.PARITY_ERROR}, {15'd0, e[8]});
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data"},  {8'd0, bus.PARALLEL_DATA_OUTPUT}, 16'd0);
      check({tag, "_valid"}, {15'd0, bus.DATA_VALID},   16'd0);
      check({tag, "_perr"},  {15'd0, bus.PARITY_ERROR}, 16'd0);
      check({tag, "_ferr"},  {15'd0, bus.FRAME_ERROR},  16'd0);
      check({tag, "_ovr"},   {15'd0, bus.OVERRUN},      16'd0);
   endtask

   task automatic accept(input string tag);
      bus.DATA_READY = 1'b1;
      tick();
      bus.DATA_READY = 1'b0;
      check({tag, "_cleared"}, {15'd0, bus.DATA_VALID}, 16'd0);
      check({tag, "_perr_cleared"}, {15'd0, bus.PARITY_ERROR}, 16'd0);
   endtask

   initial begin
      bus.SAMPLE_ENABLE  = 1'b0;
      bus.DEBOUNCED_DATA = 1'b1;
      bus.DATA_READY     = 1'b0;

      // Reset state
      tick();
      tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // 0xA5 with correct odd parity; valid rises on the stop-sample edge
      exp_q.push_back({1'b0, 8'hA5});
      send_head(8'hA5, odd_par(8'hA5));
      check("a5_pre_stop_valid", {15'd0, bus.DATA_VALID}, 16'd0);
      send_bit(1'b1);
      check_delivery("a5");
      accept("a5_accept");

      // Same frame with bad parity: still delivered, flagged
      exp_q.push_back({1'b1, 8'hA5});
      send_head(8'hA5, 1'b0);
      check("a5bad_pre_stop_valid", {15'd0, bus.DATA_VALID}, 16'd0);
      send_bit(1'b1);
      check_delivery("a5bad");
      accept("a5bad_accept");

      // Stop bit 0: dropped with one-cycle FRAME_ERROR
      send_head(8'hA5, odd_par(8'hA5));
      send_bit(1'b0);
      check("stop0_ferr",  {15'd0, bus.FRAME_ERROR}, 16'd1);
      check("stop0_valid", {15'd0, bus.DATA_VALID},  16'd0);
      check("stop0_ovr",   {15'd0, bus.OVERRUN},     16'd0);
      tick();
      check("stop0_ferr_pulse", {15'd0, bus.FRAME_ERROR}, 16'd0);

      // Overrun: 0x3C held, 0xC3 dropped
      exp_q.push_back({1'b0, 8'h3C});
      send_head(8'h3C, odd_par(8'h3C));
      send_bit(1'b1);
      check_delivery("x3c");
      send_head(8'hC3, odd_par(8'hC3));
      send_bit(1'b1);
      check("ovr_pulse", {15'd0, bus.OVERRUN},     16'd1);
      check("ovr_ferr",  {15'd0, bus.FRAME_ERROR}, 16'd0);
      check("ovr_valid", {15'd0, bus.DATA_VALID},  16'd1);
      check("ovr_held",  {8'd0, bus.PARALLEL_DATA_OUTPUT}, 16'h003C);
      tick();
      check("ovr_pulse_end", {15'd0, bus.OVERRUN}, 16'd0);
      check("ovr_stable",    {8'd0, bus.PARALLEL_DATA_OUTPUT}, 16'h003C);
      accept("ovr_accept");

      // Completion on the same edge the old word is accepted: no overrun
      exp_q.push_back({1'b0, 8'h11});
      send_head(8'h11, odd_par(8'h11));
      send_bit(1'b1);
      check_delivery("x11");
      exp_q.push_back({1'b0, 8'h7E});
      send_head(8'h7E, odd_par(8'h7E));
      bus.DATA_READY = 1'b1;
      send_bit(1'b1);
      bus.DATA_READY = 1'b0;
      check("same_edge_ovr", {15'd0, bus.OVERRUN}, 16'd0);
      check_delivery("x7e");
      accept("x7e_accept");

      // Reset mid-frame with a word pending, then a fresh 0x5A frame
      exp_q.push_back({1'b0, 8'h42});
      send_head(8'h42, odd_par(8'h42));
      send_bit(1'b1);
      check_delivery("x42");
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rst_n = 1'b0;
      #2;
      check_all_zero("midreset");
      tick();
      rst_n = 1'b1;
      tick();
      exp_q.push_back({1'b0, 8'h5A});
      send_head(8'h5A, odd_par(8'h5A));
      send_bit(1'b1);
      check_delivery("x5a");
      accept("x5a_accept");

`ifdef FRAME_TIMEOUT_EN
      // Partial frame abandoned after 16 strobe-free clocks
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      repeat (15) tick();
      check("tmo_early", {15'd0, bus.FRAME_ERROR}, 16'd0);
      tick();
      check("tmo_ferr", {15'd0, bus.FRAME_ERROR}, 16'd1);
      tick();
      check("tmo_ferr_pulse", {15'd0, bus.FRAME_ERROR}, 16'd0);
      exp_q.push_back({1'b0, 8'h81});
      send_head(8'h81, odd_par(8'h81));
      send_bit(1'b1);
      check_delivery("x81");
      accept("x81_accept");
`endif

      check("sb_empty", 16'(exp_q.size()), 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
